masked_inv_sched: RTL and testbench
===================================

# masked_inv_sched

Round-robin scheduler that shares one 2-share, first-order masked GF(2^8) inverter among up to N_REQ requesters, such as the SubBytes lanes and the key-schedule unit. The inverter is a free-running 3-stage pipeline that cannot stall. This block grants at most one request per cycle, tracks the requester tag of every in-flight byte, and routes results back. It also owns the on-chip PRNG that supplies the fresh 32 bits of randomness the inverter consumes every cycle.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- LATENCY, 3, cycles from inverter input to inverter output
- RAN_W, 32, randomness bits consumed per cycle

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- seed_valid  in  1  load PRNG seed this cycle
- seed  in  64  PRNG seed value
- flush  in  1  synchronous; drop all in-flight bytes
- req_valid  in  N_REQ  request pending, one bit per requester
- req_share0  in  8*N_REQ  share 0 per requester, requester i at [8i+7:8i]
- req_share1  in  8*N_REQ  share 1 per requester
- req_ready  out  N_REQ  one-hot grant; the handshake completes when req_valid[i] & req_ready[i]
- rsp_valid  out  N_REQ  one-hot result strobe, with no backpressure
- rsp_share0  out  8  result share 0
- rsp_share1  out  8  result share 1
- inv_in0  out  8  inverter input share 0
- inv_in1  out  8  inverter input share 1
- inv_ran  out  RAN_W  inverter randomness
- inv_out0  in  8  inverter output share 0
- inv_out1  in  8  inverter output share 1
- busy  out  1  some byte is in flight
- seeded  out  1  PRNG has been loaded since reset

## Operation
- **PRNG.**
  - State is a 64-bit xorshift64 register s. Each cycle: s ^= s<<13, then s ^= s>>7, then s ^= s<<17.
  - inv_ran is the registered s[31:0]. It advances every cycle once seeded, including idle cycles.
  - seed_valid loads seed; a zero seed loads 64'h1 instead. seed_valid sets `seeded`.
  - seed_valid has priority over advancing.
- **Arbitration.**
  - No grant is issued while seeded==0 or flush==1.
  - Otherwise, grant the first requester with req_valid set, searching from the round-robin pointer ptr upward with wrap.
  - After a grant to requester i, ptr becomes (i+1) mod N_REQ. ptr is unchanged when no grant is issued.
  - req_ready is combinational from req_valid, ptr, seeded and flush.
- **Issue.**
  - On a grant, inv_in0/inv_in1 take that requester's shares directly (combinational mux).
  - With no grant, both inputs are 8'h00.
  - The shares are never XORed or combined anywhere in this block; share 0 and share 1 stay in separate datapaths.
- **Tracking.**
  - A LATENCY-deep shift register holds {vld, tag[$clog2(N_REQ)-1:0]}. It shifts every cycle.
  - Stage 0 captures the grant.
  - flush clears every vld bit. ptr and the PRNG are unaffected.
- **Return.**
  - When the last stage has vld=1: rsp_valid[tag]=1, rsp_share0=inv_out0, rsp_share1=inv_out1. All of these are combinational from the last stage.
  - When the last stage has vld=0, rsp shares are 8'h00.
- `busy` = OR of all vld bits.

## Timing
- **Reset values.**
  - s=0, inv_ran=0, seeded=0, ptr=0, all vld=0.
  - req_ready=0, rsp_valid=0, rsp shares=0, busy=0.
- **Latency.** A request granted in cycle t returns in cycle t+LATENCY. Sustained throughput is 1 byte per cycle.
- **Fairness.** With all N_REQ requesters continuously valid, each is granted exactly once every N_REQ cycles.
- **Seed load.** seed_valid in cycle t makes seeded visible in t+1, so the first grant is possible in cycle t+1.
- **Simultaneous flush and return.** If flush is asserted in the same cycle the last stage is valid, that response is still emitted. Only bytes still in stages before the last are dropped.
- **Randomness during flush.** The PRNG keeps advancing during flush.
- **Reset mid-operation.** All state clears asynchronously, all in-flight results are lost, and a re-seed is required before any grant.

## Structure
- Shared package holds the xorshift shift constants (13, 7, 17), the zero-seed substitute 64'h1, and the tag width function.
- One sub-module, masked_prng64, implements the PRNG: seed, advance, output. The arbiter and the tracking pipeline live in the top module.
- The inverter is instantiated outside this block; benches connect a 3-cycle behavioural masked-inverse model.

## Test plan
- No seed, req_valid=4'hF for 10 cycles -> req_ready stays 0 and busy stays 0. Then seed=64'h0 -> inv_ran stream matches an xorshift64 model started at state 1.
- After seeding, requester 2 sends share0=0x53^0xA5, share1=0xA5 -> 3 cycles later rsp_valid=4'b0100 and rsp_share0^rsp_share1=0xCA; inputs of 0x00 return 0x00.
- All four requesters valid for 16 cycles from ptr=0 -> grant order 0,1,2,3 repeating. Every response tag matches its grant and every XOR-ed result is the correct inverse.
- Requesters 1 and 3 valid, with ptr=2 -> requester 3 is granted first, then 1, then 3.
- Three back-to-back grants, with flush asserted in the cycle the first result returns -> the first response is emitted and the next two are dropped. busy is 0 one cycle later.
- rst_n pulsed low mid-stream -> every output is 0 immediately. After release, no grant is issued until seed_valid.

Source files
------------

// File: rtl/masked_inv_sched_pkg.sv
// Shared constants and helpers for the masked-inverter scheduler:
// xorshift64 shift amounts, the zero-seed substitute and the tag width.
package masked_inv_sched_pkg;

    localparam int          XS_SHL_A      = 13;
    localparam int          XS_SHR_B      = 7;
    localparam int          XS_SHL_C      = 17;
    localparam logic [63:0] ZERO_SEED_SUB = 64'h0000_0000_0000_0001;

    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [63:0] xorshift64(input logic [63:0] s);
        logic [63:0] t;
        t = s ^ (s << XS_SHL_A);
        t = t ^ (t >> XS_SHR_B);
        t = t ^ (t << XS_SHL_C);
        return t;
    endfunction

endpackage

// File: rtl/masked_inv_sched_if.sv
// Requester-side bus of the scheduler: per-requester shares and handshake
// in, one-hot response strobe and result shares out.
interface masked_inv_sched_if #(parameter int N_REQ = 4);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [8*N_REQ-1:0] req_share0;
    logic [8*N_REQ-1:0] req_share1;
    logic [N_REQ-1:0]   rsp_valid;
    logic [7:0]         rsp_share0;
    logic [7:0]         rsp_share1;

    modport master (
        output req_valid, req_share0, req_share1,
        input  req_ready, rsp_valid, rsp_share0, rsp_share1
    );

    modport slave (
        input  req_valid, req_share0, req_share1,
        output req_ready, rsp_valid, rsp_share0, rsp_share1
    );

endinterface

// File: rtl/masked_prng64.sv
// xorshift64 randomness source for the masked inverter; advances every
// cycle once seeded, and a zero seed is replaced so the state never sticks.
module masked_prng64
    import masked_inv_sched_pkg::*;
#(
    parameter int RAN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_valid,
    input  logic [63:0]      seed,
    output logic [RAN_W-1:0] ran,
    output logic             seeded
);

    logic [63:0] state_r;
    logic [63:0] state_next_s;
    logic        seeded_r;

    // Next PRNG state: seed load wins over advancing
    always_comb begin
        state_next_s = state_r;
        if (seed_valid) begin
            state_next_s = (seed == 64'h0) ? ZERO_SEED_SUB : seed;
        end else if (seeded_r) begin
            state_next_s = xorshift64(state_r);
        end else begin
            state_next_s = state_r;
        end
    end

    // PRNG state and seeded flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= 64'h0;
            seeded_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            seeded_r <= seeded_r | seed_valid;
        end
    end

    assign ran    = state_r[RAN_W-1:0];
    assign seeded = seeded_r;

endmodule

// File: rtl/masked_inv_sched.sv
// Round-robin scheduler sharing one free-running masked GF(2^8) inverter:
// grants one requester per cycle, tags in-flight bytes, routes results back.
module masked_inv_sched
    import masked_inv_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 3,
    parameter int RAN_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 seed_valid,
    input  logic [63:0]          seed,
    input  logic                 flush,
    masked_inv_sched_if.slave    bus,
    output logic [7:0]           inv_in0,
    output logic [7:0]           inv_in1,
    output logic [RAN_W-1:0]     inv_ran,
    input  logic [7:0]           inv_out0,
    input  logic [7:0]           inv_out1,
    output logic                 busy,
    output logic                 seeded
);

    localparam int               TAG_W    = tag_width(N_REQ);
    localparam int               CW       = TAG_W + 1;
    localparam logic [CW-1:0]    N_REQ_W  = CW'(N_REQ);
    localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(N_REQ - 1);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [TAG_W-1:0]   ptr_r;
    logic [TAG_W-1:0]   gnt_idx_s;
    logic               gnt_any_s;
    logic [N_REQ-1:0]   grant_s;
    logic               seeded_s;
    logic [LATENCY-1:0] vld_r;
    logic [TAG_W-1:0]   tag_r [LATENCY];

    masked_prng64 #(.RAN_W(RAN_W)) u_prng (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed       (seed),
        .ran        (inv_ran),
        .seeded     (seeded_s)
    );

    assign seeded = seeded_s;

    // Search downward so the candidate nearest ptr is written last and wins
    always_comb begin
        logic [CW-1:0] cand;
        cand      = '0;
        gnt_idx_s = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand      = {1'b0, ptr_r} + CW'(k);
            cand      = (cand >= N_REQ_W) ? (cand - N_REQ_W) : cand;
            gnt_idx_s = bus.req_valid[cand[TAG_W-1:0]] ? cand[TAG_W-1:0] : gnt_idx_s;
        end
        gnt_any_s = seeded_s & ~flush & (|bus.req_valid);
        grant_s   = gnt_any_s ? (ONE_HOT0 << gnt_idx_s) : {N_REQ{1'b0}};
    end

    assign bus.req_ready = grant_s;

    // Issue mux; share 0 and share 1 travel in separate datapaths
    always_comb begin
        inv_in0 = 8'h00;
        inv_in1 = 8'h00;
        if (gnt_any_s) begin
            inv_in0 = bus.req_share0[{gnt_idx_s, 3'b000} +: 8];
            inv_in1 = bus.req_share1[{gnt_idx_s, 3'b000} +: 8];
        end else begin
            inv_in0 = 8'h00;
            inv_in1 = 8'h00;
        end
    end

    // Round-robin pointer moves past the granted requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (gnt_any_s) begin
            ptr_r <= (gnt_idx_s == TAG_LAST) ? '0 : (gnt_idx_s + TAG_ONE);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Tag pipeline tracks the inverter; flush kills everything not yet at the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int i = 0; i < LATENCY; i++) tag_r[i] <= '0;
        end else begin
            vld_r    <= flush ? {LATENCY{1'b0}} : {vld_r[LATENCY-2:0], gnt_any_s};
            tag_r[0] <= gnt_idx_s;
            for (int i = 1; i < LATENCY; i++) tag_r[i] <= tag_r[i-1];
        end
    end

    // Response routing from the last tracking stage
    always_comb begin
        bus.rsp_valid  = {N_REQ{1'b0}};
        bus.rsp_share0 = 8'h00;
        bus.rsp_share1 = 8'h00;
        if (vld_r[LATENCY-1]) begin
            bus.rsp_valid  = ONE_HOT0 << tag_r[LATENCY-1];
            bus.rsp_share0 = inv_out0;
            bus.rsp_share1 = inv_out1;
        end else begin
            bus.rsp_valid  = {N_REQ{1'b0}};
            bus.rsp_share0 = 8'h00;
            bus.rsp_share1 = 8'h00;
        end
    end

    assign busy = |vld_r;

endmodule

// File: tb/tb_masked_inv_sched.sv
// Self-checking bench for masked_inv_sched with a 3-cycle behavioural masked
// inverter and a scoreboard of expected responses keyed by due cycle.
module tb_masked_inv_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seed_valid = 1'b0;
    logic [63:0] seed = 64'h0;
    logic        flush = 1'b0;
    logic [7:0]  inv_in0, inv_in1, inv_out0, inv_out1;
    logic [31:0] inv_ran;
    logic        busy, seeded;

    masked_inv_sched_if #(.N_REQ(4)) bus();

    masked_inv_sched #(.N_REQ(4), .LATENCY(3), .RAN_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed), .flush(flush),
        .bus(bus), .inv_in0(inv_in0), .inv_in1(inv_in1), .inv_ran(inv_ran),
        .inv_out0(inv_out0), .inv_out1(inv_out1), .busy(busy), .seeded(seeded)
    );

    typedef struct {
        int         due;
        int         tag;
        logic [7:0] val;
    } sb_t;

    sb_t  sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;
    bit   m_seeded = 1'b0;
    int   m_ptr   = 0;
    logic [15:0] inv_pipe [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gf_mul(r, a);
        return r;
    endfunction

    function automatic logic [63:0] xs_model(input logic [63:0] s);
        logic [63:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    // Behavioural masked inverter: remasks the inverse with fresh randomness
    always @(posedge clk) begin
        inv_pipe[0] <= {gf_inv(inv_in0 ^ inv_in1) ^ inv_ran[7:0], inv_ran[7:0]};
        inv_pipe[1] <= inv_pipe[0];
        inv_pipe[2] <= inv_pipe[1];
    end
    assign inv_out0 = inv_pipe[2][15:8];
    assign inv_out1 = inv_pipe[2][7:0];

    // Response scoreboard
    always @(negedge clk) begin
        sb_t e;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                vectors++;
                if (e.due != cyc || bus.rsp_valid !== (4'b0001 << e.tag) ||
                    (bus.rsp_share0 ^ bus.rsp_share1) !== e.val) begin
                    errors++;
                    $display("FAIL rsp cyc=%0d got valid=%b val=%h, expected due=%0d valid=%b val=%h",
                             cyc, bus.rsp_valid, bus.rsp_share0 ^ bus.rsp_share1,
                             e.due, 4'b0001 << e.tag, e.val);
                end
            end else begin
                vectors++;
                if (bus.rsp_valid !== 4'h0 || bus.rsp_share0 !== 8'h00 || bus.rsp_share1 !== 8'h00) begin
                    errors++;
                    $display("FAIL rsp_idle cyc=%0d got valid=%b s0=%h s1=%h, expected all zero",
                             cyc, bus.rsp_valid, bus.rsp_share0, bus.rsp_share1);
                end
            end
        end
    end

    task automatic issue_cycle(input logic [3:0] v, input logic [31:0] s0,
                               input logic [31:0] s1, input logic fl);
        int         g;
        logic [3:0] exp_rdy;
        logic [7:0] e0, e1;
        sb_t        ent;
        g = -1;
        exp_rdy = 4'h0;
        e0 = 8'h00;
        e1 = 8'h00;
        bus.req_valid  = v;
        bus.req_share0 = s0;
        bus.req_share1 = s1;
        flush = fl;
        if (fl) begin
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due > cyc) sb.delete(i);
        end
        if (m_seeded && !fl) begin
            for (int k = 3; k >= 0; k--) if (v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            e0 = s0[8*g +: 8];
            e1 = s1[8*g +: 8];
        end
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL grant cyc=%0d got=%b expected=%b", cyc, bus.req_ready, exp_rdy);
        end
        vectors++;
        if ({inv_in0, inv_in1} !== {e0, e1}) begin
            errors++;
            $display("FAIL inv_in cyc=%0d got=%h/%h expected=%h/%h", cyc, inv_in0, inv_in1, e0, e1);
        end
        if (g >= 0) begin
            ent.due = cyc + 3;
            ent.tag = g;
            ent.val = gf_inv(e0 ^ e1);
            sb.push_back(ent);
            m_ptr = (g + 1) % 4;
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic do_seed(input logic [63:0] sd);
        bus.req_valid = 4'h0;
        seed_valid = 1'b1;
        seed = sd;
        @(posedge clk);
        #1;
        seed_valid = 1'b0;
        m_seeded = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid  = 4'hF;
        bus.req_share0 = 32'h0;
        bus.req_share1 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got=%b expected=0000", bus.req_ready); end
        vectors++;
        if ({seeded, busy} !== 2'b00) begin errors++; $display("FAIL reset_flags got seeded=%b busy=%b expected 0/0", seeded, busy); end
        vectors++;
        if (inv_ran !== 32'h0) begin errors++; $display("FAIL reset_ran got=%h expected=0", inv_ran); end
        vectors++;
        if (bus.rsp_valid !== 4'h0 || bus.rsp_share0 !== 8'h00 || bus.rsp_share1 !== 8'h00) begin
            errors++; $display("FAIL reset_rsp got valid=%b s0=%h s1=%h expected zero", bus.rsp_valid, bus.rsp_share0, bus.rsp_share1);
        end
        rst_n = 1'b1;
        bus.req_valid = 4'h0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    task automatic test_no_seed();
        for (int i = 0; i < 10; i++) begin
            issue_cycle(4'hF, 32'h01020304, 32'h05060708, 1'b0);
            vectors++;
            if (busy !== 1'b0 || inv_ran !== 32'h0) begin
                errors++; $display("FAIL unseeded_idle got busy=%b ran=%h expected 0/0", busy, inv_ran);
            end
        end
    endtask

    task automatic test_prng();
        logic [63:0] m;
        do_seed(64'h0);
        m = 64'h1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (inv_ran !== m[31:0] || seeded !== 1'b1) begin
                errors++; $display("FAIL prng step=%0d got ran=%h seeded=%b expected ran=%h seeded=1", i, inv_ran, seeded, m[31:0]);
            end
            m = xs_model(m);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_single();
        issue_cycle(4'b0100, 32'h00F60000, 32'h00A50000, 1'b0);
        issue_cycle(4'b0100, 32'h00000000, 32'h00000000, 1'b0);
        repeat (4) issue_cycle(4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_round_robin();
        issue_cycle(4'b1000, 32'h3C000000, 32'h81000000, 1'b0);
        for (int i = 0; i < 16; i++) issue_cycle(4'hF, $urandom, $urandom, 1'b0);
        repeat (4) issue_cycle(4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_ptr_wrap();
        issue_cycle(4'b0010, 32'h00007700, 32'h00001100, 1'b0);
        repeat (3) issue_cycle(4'b1010, $urandom, $urandom, 1'b0);
        repeat (4) issue_cycle(4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        repeat (3) issue_cycle(4'b0111, $urandom, $urandom, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_inflight got=%b expected=1", busy); end
        issue_cycle(4'hF, $urandom, $urandom, 1'b1);
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_flush got=%b expected=0", busy); end
        repeat (4) issue_cycle(4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        repeat (2) issue_cycle(4'hF, 32'h11223344, 32'h55667788, 1'b0);
        rst_n = 1'b0;
        mon_en = 1'b0;
        #2;
        vectors++;
        if (bus.req_ready !== 4'h0 || {inv_in0, inv_in1} !== 16'h0) begin
            errors++; $display("FAIL midreset_issue got ready=%b in=%h/%h expected zero", bus.req_ready, inv_in0, inv_in1);
        end
        vectors++;
        if (bus.rsp_valid !== 4'h0 || bus.rsp_share0 !== 8'h00 || bus.rsp_share1 !== 8'h00) begin
            errors++; $display("FAIL midreset_rsp got valid=%b s0=%h s1=%h expected zero", bus.rsp_valid, bus.rsp_share0, bus.rsp_share1);
        end
        vectors++;
        if (inv_ran !== 32'h0 || busy !== 1'b0 || seeded !== 1'b0) begin
            errors++; $display("FAIL midreset_state got ran=%h busy=%b seeded=%b expected zero", inv_ran, busy, seeded);
        end
        sb.delete();
        m_seeded = 1'b0;
        m_ptr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) issue_cycle(4'hF, 32'h0, 32'h0, 1'b0);
        do_seed(64'hDEAD_BEEF_0BAD_F00D);
        issue_cycle(4'b0001, 32'h000000AB, 32'h000000CD, 1'b0);
        repeat (4) issue_cycle(4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_no_seed();
        test_prng();
        test_single();
        test_round_robin();
        test_ptr_wrap();
        test_back_to_back();
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
